// File: rtl/if_stage.sv
// Instruction fetch stage: holds the PC, latches fetched instructions into
// the IF/ID register, stops fetching at HLT and freezes once HLT retires.
module if_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        halt_retired,
    input  logic [15:0] imem_data,
    output logic [15:0] pc,
    output logic [15:0] if_id_inst,
    output logic [15:0] if_id_pc2,
    output logic        if_id_valid,
    output logic        fetching,
    output logic [15:0] fetch_cnt,
    output logic [1:0]  state_dbg
);

    // Handshake: there is no valid/ready pair here; stall=1 holds every
    // register in place, branch_taken flushes IF/ID and redirects the PC, and
    // if_id_valid=1 marks a real instruction, valid on every cycle it is high.

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALT_WAIT = 2'd1,
        HALTED    = 2'd2
    } state_e;

    state_e      st_q, st_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] inst_q, inst_d;
    logic [15:0] pc2_q, pc2_d;
    logic        valid_q, valid_d;
    logic [15:0] cnt_q, cnt_d;

    logic [15:0] pc_plus2;
    logic [15:0] target_aligned;
    logic        is_hlt;

    assign pc_plus2       = pc_q + 16'd2;
    assign target_aligned = branch_target & 16'hFFFE;
    assign is_hlt         = (imem_data[15:12] == HALT_OPCODE);

    // State register; reset returns to RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q <= RUN;
        end else begin
            st_q <= st_d;
        end
    end

    // Next state: retirement of HLT beats a branch; a branch beats a stall.
    always_comb begin
        st_d = st_q;
        if (halt_retired) begin
            st_d = HALTED;
        end else begin
            case (st_q)
                RUN: begin
                    if (!branch_taken && !stall && is_hlt) begin
                        st_d = HALT_WAIT;
                    end
                end
                HALT_WAIT: begin
                    if (branch_taken) begin
                        st_d = RUN;
                    end
                end
                HALTED:  st_d = HALTED;
                default: st_d = RUN;
            endcase
        end
    end

    // Datapath next values for PC, IF/ID and the fetch counter.
    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        pc2_d   = pc2_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (halt_retired || st_q == HALTED) begin
            // Frozen: PC holds, IF/ID becomes and stays a bubble.
            inst_d  = 16'h0000;
            valid_d = 1'b0;
        end else if (branch_taken) begin
            pc_d    = target_aligned;
            inst_d  = 16'h0000;
            valid_d = 1'b0;
        end else if (!stall) begin
            case (st_q)
                RUN: begin
                    inst_d  = imem_data;
                    pc2_d   = pc_plus2;
                    valid_d = 1'b1;
                    cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                    // A fetched HLT parks the PC on itself.
                    pc_d    = is_hlt ? pc_q : pc_plus2;
                end
                HALT_WAIT: begin
                    // HLT has moved downstream; leave a bubble behind it.
                    inst_d  = 16'h0000;
                    valid_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            inst_q  <= 16'h0000;
            pc2_q   <= 16'h0000;
            valid_q <= 1'b0;
            cnt_q   <= 16'h0000;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pc2_q   <= pc2_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc          = pc_q;
    assign if_id_inst  = inst_q;
    assign if_id_pc2   = pc2_q;
    assign if_id_valid = valid_q;
    assign fetching    = (st_q == RUN);
    assign fetch_cnt   = cnt_q;
    assign state_dbg   = st_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: each step drives one cycle of inputs and
// queues the hand-computed register contents expected after that edge.
module tb_if_stage;

    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_HW  = 2'd1;
    localparam logic [1:0] S_HLT = 2'd2;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        halt_retired;
    logic [15:0] imem_data;
    logic [15:0] pc;
    logic [15:0] if_id_inst;
    logic [15:0] if_id_pc2;
    logic        if_id_valid;
    logic        fetching;
    logic [15:0] fetch_cnt;
    logic [1:0]  state_dbg;

    typedef struct packed {
        logic [7:0]  tag;
        logic [15:0] pc;
        logic [15:0] inst;
        logic [15:0] pc2;
        logic        valid;
        logic [1:0]  st;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   failures;

    if_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halt_retired (halt_retired),
        .imem_data    (imem_data),
        .pc           (pc),
        .if_id_inst   (if_id_inst),
        .if_id_pc2    (if_id_pc2),
        .if_id_valid  (if_id_valid),
        .fetching     (fetching),
        .fetch_cnt    (fetch_cnt),
        .state_dbg    (state_dbg)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs (at the falling edge) and queue the expectation.
    task automatic step(input logic [7:0] tag, input logic r, input logic br,
                        input logic [15:0] tgt, input logic stl, input logic hr,
                        input logic [15:0] im, input logic [15:0] e_pc,
                        input logic [15:0] e_inst, input logic [15:0] e_pc2,
                        input logic e_v, input logic [1:0] e_st,
                        input logic [15:0] e_cnt);
        exp_t e;
        @(negedge clk);
        rst_n         = r;
        branch_taken  = br;
        branch_target = tgt;
        stall         = stl;
        halt_retired  = hr;
        imem_data     = im;
        e.tag = tag; e.pc = e_pc; e.inst = e_inst; e.pc2 = e_pc2;
        e.valid = e_v; e.st = e_st; e.cnt = e_cnt;
        exp_q.push_back(e);
    endtask

    // Drive a plain fetch cycle with no expectation queued.
    task automatic run_free(input logic [15:0] im);
        @(negedge clk);
        rst_n = 1'b1; branch_taken = 1'b0; stall = 1'b0; halt_retired = 1'b0;
        branch_target = 16'h0000;
        imem_data = im;
    endtask

    // Monitor: after every rising edge, compare the DUT against the oldest expectation.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (pc !== e.pc || if_id_inst !== e.inst || if_id_pc2 !== e.pc2 ||
                if_id_valid !== e.valid || state_dbg !== e.st ||
                fetching !== (e.st == S_RUN) || fetch_cnt !== e.cnt) begin
                failures++;
                $display("FAIL step%0d got pc=%h inst=%h pc2=%h v=%b st=%0d f=%b cnt=%h want pc=%h inst=%h pc2=%h v=%b st=%0d f=%b cnt=%h",
                         e.tag, pc, if_id_inst, if_id_pc2, if_id_valid, state_dbg, fetching, fetch_cnt,
                         e.pc, e.inst, e.pc2, e.valid, e.st, (e.st == S_RUN), e.cnt);
            end
        end
    end

    initial begin
        int wait_cycles;
        checks = 0; failures = 0;
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
        halt_retired = 1'b0; imem_data = 16'h0000;

        //      tag r  br tgt       st hr imem      pc        inst      pc2       v     st     cnt
        step(1,  0, 0, 16'h0000, 0, 0, 16'hF000, 16'h0000, 16'h0000, 16'h0000, 1'b0, S_RUN, 16'h0000);
        step(2,  1, 0, 16'h0000, 0, 0, 16'h1234, 16'h0002, 16'h1234, 16'h0002, 1'b1, S_RUN, 16'h0001);
        step(3,  1, 0, 16'h0000, 0, 0, 16'h5678, 16'h0004, 16'h5678, 16'h0004, 1'b1, S_RUN, 16'h0002);
        // Branch with odd target: bit 0 dropped, IF/ID flushed, bubble not counted.
        step(4,  1, 1, 16'h0011, 0, 0, 16'hAAAA, 16'h0010, 16'h0000, 16'h0004, 1'b0, S_RUN, 16'h0002);
        // Three stalled edges at 0x0010.
        step(5,  1, 0, 16'h0000, 1, 0, 16'h1111, 16'h0010, 16'h0000, 16'h0004, 1'b0, S_RUN, 16'h0002);
        step(6,  1, 0, 16'h0000, 1, 0, 16'h1111, 16'h0010, 16'h0000, 16'h0004, 1'b0, S_RUN, 16'h0002);
        step(7,  1, 0, 16'h0000, 1, 0, 16'h1111, 16'h0010, 16'h0000, 16'h0004, 1'b0, S_RUN, 16'h0002);
        step(8,  1, 0, 16'h0000, 0, 0, 16'h1111, 16'h0012, 16'h1111, 16'h0012, 1'b1, S_RUN, 16'h0003);
        // Branch overrides stall.
        step(9,  1, 1, 16'h0041, 1, 0, 16'hBBBB, 16'h0040, 16'h0000, 16'h0012, 1'b0, S_RUN, 16'h0003);
        step(10, 1, 1, 16'h0020, 0, 0, 16'hCCCC, 16'h0020, 16'h0000, 16'h0012, 1'b0, S_RUN, 16'h0003);
        // HLT at 0x0020.
        step(11, 1, 0, 16'h0000, 0, 0, 16'hF000, 16'h0020, 16'hF000, 16'h0022, 1'b1, S_HW,  16'h0004);
        step(12, 1, 0, 16'h0000, 1, 0, 16'hF000, 16'h0020, 16'hF000, 16'h0022, 1'b1, S_HW,  16'h0004);
        step(13, 1, 0, 16'h0000, 0, 0, 16'hF000, 16'h0020, 16'h0000, 16'h0022, 1'b0, S_HW,  16'h0004);
        step(14, 1, 0, 16'h0000, 0, 0, 16'hF000, 16'h0020, 16'h0000, 16'h0022, 1'b0, S_HW,  16'h0004);
        step(15, 1, 1, 16'h0100, 0, 0, 16'hF000, 16'h0100, 16'h0000, 16'h0022, 1'b0, S_RUN, 16'h0004);
        step(16, 1, 0, 16'h0000, 0, 0, 16'h2222, 16'h0102, 16'h2222, 16'h0102, 1'b1, S_RUN, 16'h0005);
        step(17, 1, 0, 16'h0000, 0, 0, 16'hF123, 16'h0102, 16'hF123, 16'h0104, 1'b1, S_HW,  16'h0006);
        // Retirement beats a simultaneous branch; HALTED ignores later branches/fetches.
        step(18, 1, 1, 16'h0200, 0, 1, 16'hF123, 16'h0102, 16'h0000, 16'h0104, 1'b0, S_HLT, 16'h0006);
        step(19, 1, 1, 16'h0300, 0, 0, 16'hF123, 16'h0102, 16'h0000, 16'h0104, 1'b0, S_HLT, 16'h0006);
        step(20, 1, 0, 16'h0000, 0, 0, 16'h3333, 16'h0102, 16'h0000, 16'h0104, 1'b0, S_HLT, 16'h0006);
        // Reset overrides branch and stall.
        step(21, 0, 1, 16'h0500, 1, 0, 16'h3333, 16'h0000, 16'h0000, 16'h0000, 1'b0, S_RUN, 16'h0000);
        step(22, 1, 0, 16'h0000, 0, 0, 16'h4444, 16'h0002, 16'h4444, 16'h0002, 1'b1, S_RUN, 16'h0001);
        // Retirement straight from RUN.
        step(23, 1, 0, 16'h0000, 0, 1, 16'h5555, 16'h0002, 16'h0000, 16'h0002, 1'b0, S_HLT, 16'h0001);
        step(24, 0, 0, 16'h0000, 0, 0, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 1'b0, S_RUN, 16'h0000);
        // PC wrap at 0xFFFE.
        step(25, 1, 1, 16'hFFFE, 0, 0, 16'h5555, 16'hFFFE, 16'h0000, 16'h0000, 1'b0, S_RUN, 16'h0000);
        step(26, 1, 0, 16'h0000, 0, 0, 16'h7777, 16'h0000, 16'h7777, 16'h0000, 1'b1, S_RUN, 16'h0001);
        // 65544 free fetches: count reaches FFFF after 65534, pc ends at 2*65544 mod 2^16 = 0x0010.
        for (int i = 0; i < 65544; i++) run_free(16'h0001);
        step(27, 1, 0, 16'h0000, 0, 0, 16'h0002, 16'h0012, 16'h0002, 16'h0012, 1'b1, S_RUN, 16'hFFFF);
        step(28, 1, 0, 16'h0000, 0, 0, 16'h0003, 16'h0014, 16'h0003, 16'h0014, 1'b1, S_RUN, 16'hFFFF);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
